// File: rtl/rob_queue_param_if.sv
// Bundle of all ROB-facing signals: issue, CDB writeback, operand lookup, commit,
// predictor update, redirect and occupancy.
interface rob_queue_param_if #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32
);
  localparam int TAG_W = $clog2(DEPTH);

  logic              iss_valid;
  logic              iss_ready;
  logic [1:0]        iss_kind;
  logic [4:0]        iss_dest;
  logic [31:0]       iss_pc;
  logic              iss_pred_taken;
  logic [TAG_W-1:0]  iss_tag;

  logic              wb_valid;
  logic [TAG_W-1:0]  wb_tag;
  logic [DATA_W-1:0] wb_value;
  logic              wb_taken;
  logic [31:0]       wb_target;

  logic [TAG_W-1:0]  rd_tag_a, rd_tag_b;
  logic              rd_ready_a, rd_ready_b;
  logic [DATA_W-1:0] rd_value_a, rd_value_b;

  logic              st_ready;
  logic              cm_valid;
  logic [1:0]        cm_kind;
  logic [4:0]        cm_dest;
  logic [DATA_W-1:0] cm_value;
  logic [TAG_W-1:0]  cm_tag;

  logic              bp_upd_valid;
  logic [31:0]       bp_upd_pc;
  logic              bp_upd_taken;
  logic              flush;
  logic [31:0]       flush_pc;

  logic [TAG_W:0]    count;
  logic              empty, full;

  modport master (
    output iss_valid, iss_kind, iss_dest, iss_pc, iss_pred_taken,
           wb_valid, wb_tag, wb_value, wb_taken, wb_target,
           rd_tag_a, rd_tag_b, st_ready,
    input  iss_ready, iss_tag, rd_ready_a, rd_ready_b, rd_value_a, rd_value_b,
           cm_valid, cm_kind, cm_dest, cm_value, cm_tag,
           bp_upd_valid, bp_upd_pc, bp_upd_taken, flush, flush_pc,
           count, empty, full
  );

  modport slave (
    input  iss_valid, iss_kind, iss_dest, iss_pc, iss_pred_taken,
           wb_valid, wb_tag, wb_value, wb_taken, wb_target,
           rd_tag_a, rd_tag_b, st_ready,
    output iss_ready, iss_tag, rd_ready_a, rd_ready_b, rd_value_a, rd_value_b,
           cm_valid, cm_kind, cm_dest, cm_value, cm_tag,
           bp_upd_valid, bp_upd_pc, bp_upd_taken, flush, flush_pc,
           count, empty, full
  );
endinterface

// File: rtl/rob_queue_param.sv
// In-order reorder buffer: tag allocation, CDB writeback, two operand lookups,
// one in-order retire per cycle, branch resolution and full flush at commit.
module rob_queue_param #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32
) (
  input logic             clk,
  input logic             rst_n,
  rob_queue_param_if.slave bus
);
  localparam int TAG_W = $clog2(DEPTH);
  localparam logic [1:0] K_REG = 2'd0, K_ST = 2'd1, K_BR = 2'd2, K_NOP = 2'd3;

  typedef struct packed {
    logic              valid;
    logic              ready;
    logic [1:0]        kind;
    logic [4:0]        dest;
    logic [31:0]       pc;
    logic              pred;
    logic              taken;
    logic [31:0]       target;
    logic [DATA_W-1:0] value;
  } entry_t;

  entry_t           ent [DEPTH];
  logic [TAG_W-1:0] head, tail;
  logic [TAG_W:0]   cnt;

  entry_t hd;
  logic   empty, full, cm_fire, is_br, mispred, iss_fire;

  assign hd       = ent[head];
  assign empty    = (cnt == '0);
  assign full     = (cnt == (TAG_W+1)'(DEPTH));
  // Commit looks only at the registered ready bit; a CDB result retires next cycle at the earliest.
  assign cm_fire  = !empty && hd.ready && (hd.kind != K_ST || bus.st_ready);
  assign is_br    = cm_fire && (hd.kind == K_BR);
  assign mispred  = is_br && (hd.pred != hd.taken);
  assign iss_fire = bus.iss_valid && bus.iss_ready;

  assign bus.iss_ready    = !full && !mispred;
  assign bus.iss_tag      = tail;
  assign bus.cm_valid     = cm_fire;
  assign bus.cm_kind      = cm_fire ? hd.kind  : '0;
  assign bus.cm_dest      = cm_fire ? hd.dest  : '0;
  assign bus.cm_value     = cm_fire ? hd.value : '0;
  assign bus.cm_tag       = head;
  assign bus.bp_upd_valid = is_br;
  assign bus.bp_upd_pc    = is_br ? hd.pc    : '0;
  assign bus.bp_upd_taken = is_br ? hd.taken : 1'b0;
  assign bus.flush        = mispred;
  assign bus.flush_pc     = !mispred ? '0 : (hd.taken ? hd.target : hd.pc + 32'd1);
  assign bus.count        = cnt;
  assign bus.empty        = empty;
  assign bus.full         = full;

  function automatic logic lk_ready(input logic [TAG_W-1:0] t);
    return ent[t].valid && (ent[t].ready || (bus.wb_valid && bus.wb_tag == t));
  endfunction

  function automatic logic [DATA_W-1:0] lk_value(input logic [TAG_W-1:0] t);
    if (!ent[t].valid)                        return '0;
    else if (bus.wb_valid && bus.wb_tag == t) return bus.wb_value;
    else if (ent[t].ready)                    return ent[t].value;
    else                                      return '0;
  endfunction

  assign bus.rd_ready_a = lk_ready(bus.rd_tag_a);
  assign bus.rd_ready_b = lk_ready(bus.rd_tag_b);
  assign bus.rd_value_a = lk_value(bus.rd_tag_a);
  assign bus.rd_value_b = lk_value(bus.rd_tag_b);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else if (mispred) begin
      // Everything younger than the branch is wrong-path; restart empty just past it.
      for (int i = 0; i < DEPTH; i++) begin
        ent[i].valid <= 1'b0;
        ent[i].ready <= 1'b0;
      end
      head <= head + TAG_W'(1);
      tail <= head + TAG_W'(1);
      cnt  <= '0;
    end else begin
      if (bus.wb_valid && ent[bus.wb_tag].valid) begin
        ent[bus.wb_tag].ready  <= 1'b1;
        ent[bus.wb_tag].value  <= bus.wb_value;
        ent[bus.wb_tag].taken  <= bus.wb_taken;
        ent[bus.wb_tag].target <= bus.wb_target;
      end
      if (cm_fire) begin
        ent[head].valid <= 1'b0;
        ent[head].ready <= 1'b0;
        head            <= head + TAG_W'(1);
      end
      // Tail never aliases a valid entry when issue fires (count < DEPTH), so no conflict with the above.
      if (iss_fire) begin
        ent[tail] <= '{valid:  1'b1,
                       ready:  (bus.iss_kind == K_NOP),
                       kind:   bus.iss_kind,
                       dest:   bus.iss_dest,
                       pc:     bus.iss_pc,
                       pred:   bus.iss_pred_taken,
                       taken:  1'b0,
                       target: 32'd0,
                       value:  '0};
        tail <= tail + TAG_W'(1);
      end
      case ({iss_fire, cm_fire})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  logic unused_k;
  assign unused_k = ^{K_REG};
endmodule

// File: tb/tb_rob_queue_param.sv
// Directed bench for rob_queue_param: issue-time scoreboard of expected commits,
// checked in program order by a commit monitor, plus point checks on each scenario.
module tb_rob_queue_param;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rob_queue_param_if #(.DEPTH(16), .DATA_W(32)) bus ();
  rob_queue_param #(.DEPTH(16), .DATA_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [1:0] kind;
    logic [4:0] dest;
    logic [3:0] tag;
  } exp_t;

  exp_t        sb[$];
  exp_t        me;
  logic [31:0] mval [16];
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [1:0] k, input logic [4:0] d, input logic [31:0] pc,
                       input logic pr, input logic [3:0] etag);
    bus.iss_valid = 1'b1; bus.iss_kind = k; bus.iss_dest = d;
    bus.iss_pc = pc; bus.iss_pred_taken = pr;
    #1;
    chk("iss_ready", bus.iss_ready, 1'b1);
    chk("iss_tag", bus.iss_tag, etag);
    sb.push_back('{kind: k, dest: d, tag: etag});
    if (k == 2'd3) mval[etag] = 32'd0;
    tick();
    bus.iss_valid = 1'b0;
  endtask

  task automatic wb(input logic [3:0] t, input logic [31:0] v, input logic tk, input logic [31:0] tgt);
    bus.wb_valid = 1'b1; bus.wb_tag = t; bus.wb_value = v;
    bus.wb_taken = tk; bus.wb_target = tgt;
    mval[t] = v;
    tick();
    bus.wb_valid = 1'b0;
  endtask

  // Every retirement must match the oldest outstanding issue.
  always @(negedge clk) begin
    if (rst_n && bus.cm_valid) begin
      if (sb.size() == 0) chk("cm_unexpected", bus.cm_valid, 1'b0);
      else begin
        me = sb.pop_front();
        chk("cm_tag", bus.cm_tag, me.tag);
        chk("cm_kind", bus.cm_kind, me.kind);
        chk("cm_dest", bus.cm_dest, me.dest);
        chk("cm_value", bus.cm_value, mval[me.tag]);
        if (bus.flush) sb.delete();
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.iss_valid = 0; bus.iss_kind = 0; bus.iss_dest = 0; bus.iss_pc = 0; bus.iss_pred_taken = 0;
    bus.wb_valid = 0; bus.wb_tag = 0; bus.wb_value = 0; bus.wb_taken = 0; bus.wb_target = 0;
    bus.rd_tag_a = 0; bus.rd_tag_b = 0; bus.st_ready = 1'b1;
    for (int i = 0; i < 16; i++) mval[i] = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state
    chk("rst_iss_ready", bus.iss_ready, 1'b1);
    chk("rst_empty", bus.empty, 1'b1);
    chk("rst_full", bus.full, 1'b0);
    chk("rst_count", bus.count, 0);
    chk("rst_cm_valid", bus.cm_valid, 1'b0);
    chk("rst_flush", bus.flush, 1'b0);
    chk("rst_bp_upd", bus.bp_upd_valid, 1'b0);
    chk("rst_rd_ready_a", bus.rd_ready_a, 1'b0);
    chk("rst_iss_tag", bus.iss_tag, 0);

    // three reg-writes, out-of-order writeback, in-order retire
    issue(2'd0, 5'd1, 32'h0, 1'b0, 4'd0);
    issue(2'd0, 5'd2, 32'h1, 1'b0, 4'd1);
    issue(2'd0, 5'd3, 32'h2, 1'b0, 4'd2);
    chk("count3", bus.count, 3);
    wb(4'd1, 32'h111, 1'b0, 32'h0);
    chk("no_cm_head_busy", bus.cm_valid, 1'b0);
    bus.rd_tag_a = 4'd1;
    #1;
    chk("rd_ready_a_reg", bus.rd_ready_a, 1'b1);
    chk("rd_value_a_reg", bus.rd_value_a, 32'h111);
    bus.wb_valid = 1'b1; bus.wb_tag = 4'd0; bus.wb_value = 32'h100; mval[0] = 32'h100;
    #1;
    chk("no_cm_same_cycle_wb", bus.cm_valid, 1'b0);
    tick();
    bus.wb_valid = 1'b0;
    tick();
    chk("count_after_1st", bus.count, 2);
    tick();
    wb(4'd2, 32'h222, 1'b0, 32'h0);
    tick();
    chk("empty_after_3", bus.empty, 1'b1);
    chk("count_after_3", bus.count, 0);

    // fill from a fresh reset, overflow attempt, drain, wrap
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int i = 0; i < 16; i++) issue(2'd0, 5'(i + 1), 32'(i), 1'b0, 4'(i));
    chk("full", bus.full, 1'b1);
    chk("full_count", bus.count, 16);
    bus.iss_valid = 1'b1; bus.iss_kind = 2'd0; bus.iss_dest = 5'd31;
    #1;
    chk("full_iss_ready", bus.iss_ready, 1'b0);
    tick();
    bus.iss_valid = 1'b0;
    chk("full_count_hold", bus.count, 16);
    for (int i = 0; i < 16; i++) wb(4'(i), 32'h1000 + 32'(i), 1'b0, 32'h0);
    repeat (3) tick();
    chk("drain_empty", bus.empty, 1'b1);
    chk("drain_count", bus.count, 0);
    chk("wrap_iss_tag", bus.iss_tag, 0);

    // mispredicted branch (pred 0, taken 1) with two younger entries
    issue(2'd2, 5'd0, 32'h40, 1'b0, 4'd0);
    issue(2'd0, 5'd5, 32'h44, 1'b0, 4'd1);
    issue(2'd0, 5'd6, 32'h48, 1'b0, 4'd2);
    wb(4'd1, 32'hA1, 1'b0, 32'h0);
    wb(4'd2, 32'hA2, 1'b0, 32'h0);
    wb(4'd0, 32'h0, 1'b1, 32'h80);
    bus.iss_valid = 1'b1; bus.iss_kind = 2'd0; bus.iss_dest = 5'd9;
    bus.wb_valid = 1'b1; bus.wb_tag = 4'd1; bus.wb_value = 32'hBAD;
    #1;
    chk("mp_flush", bus.flush, 1'b1);
    chk("mp_flush_pc", bus.flush_pc, 32'h80);
    chk("mp_bp_valid", bus.bp_upd_valid, 1'b1);
    chk("mp_bp_pc", bus.bp_upd_pc, 32'h40);
    chk("mp_bp_taken", bus.bp_upd_taken, 1'b1);
    chk("mp_iss_ready", bus.iss_ready, 1'b0);
    tick();
    bus.iss_valid = 1'b0; bus.wb_valid = 1'b0; bus.rd_tag_a = 4'd1;
    #1;
    chk("mp_count", bus.count, 0);
    chk("mp_empty", bus.empty, 1'b1);
    chk("mp_iss_tag", bus.iss_tag, 1);
    chk("mp_rd_flushed", bus.rd_ready_a, 1'b0);

    // mispredict not-taken: redirect to pc+1
    issue(2'd2, 5'd0, 32'h10, 1'b1, 4'd1);
    wb(4'd1, 32'h0, 1'b0, 32'h999);
    chk("nt_flush", bus.flush, 1'b1);
    chk("nt_flush_pc", bus.flush_pc, 32'h11);
    chk("nt_bp_taken", bus.bp_upd_taken, 1'b0);
    tick();

    // correctly predicted branch
    issue(2'd2, 5'd0, 32'h20, 1'b1, 4'd2);
    wb(4'd2, 32'h0, 1'b1, 32'h30);
    chk("ok_bp_valid", bus.bp_upd_valid, 1'b1);
    chk("ok_bp_pc", bus.bp_upd_pc, 32'h20);
    chk("ok_flush", bus.flush, 1'b0);
    tick();
    chk("ok_iss_tag", bus.iss_tag, 3);

    // store stalls while memory is not ready
    bus.st_ready = 1'b0;
    issue(2'd1, 5'd0, 32'h50, 1'b0, 4'd3);
    wb(4'd3, 32'h5, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("st_stall", bus.cm_valid, 1'b0);
      tick();
    end
    bus.st_ready = 1'b1;
    #1;
    chk("st_go", bus.cm_valid, 1'b1);
    chk("st_kind", bus.cm_kind, 1);
    tick();
    chk("st_count", bus.count, 0);

    // lookup bypass, writeback to invalid tag, mid-stream reset
    issue(2'd0, 5'd7, 32'h60, 1'b0, 4'd4);
    issue(2'd0, 5'd8, 32'h64, 1'b0, 4'd5);
    bus.rd_tag_a = 4'd5; bus.rd_tag_b = 4'd4;
    bus.wb_valid = 1'b1; bus.wb_tag = 4'd5; bus.wb_value = 32'hDEAD; mval[5] = 32'hDEAD;
    #1;
    chk("byp_ready_a", bus.rd_ready_a, 1'b1);
    chk("byp_value_a", bus.rd_value_a, 32'hDEAD);
    chk("byp_ready_b", bus.rd_ready_b, 1'b0);
    chk("byp_value_b", bus.rd_value_b, 0);
    tick();
    bus.wb_tag = 4'd9; bus.wb_value = 32'hBEEF;
    tick();
    bus.wb_valid = 1'b0; bus.rd_tag_b = 4'd9;
    #1;
    chk("wb_invalid_ignored", bus.rd_ready_b, 1'b0);
    chk("reg_value_a", bus.rd_value_a, 32'hDEAD);
    rst_n = 1'b0;
    sb.delete();
    tick();
    rst_n = 1'b1;
    #1;
    chk("midrst_empty", bus.empty, 1'b1);
    chk("midrst_count", bus.count, 0);
    chk("midrst_rd_a", bus.rd_ready_a, 1'b0);
    chk("midrst_iss_tag", bus.iss_tag, 0);

    // nop retires without a writeback
    issue(2'd3, 5'd0, 32'h70, 1'b0, 4'd0);
    tick();
    chk("nop_empty", bus.empty, 1'b1);
    chk("sb_drained", 64'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
